// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/execute_muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_restore_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, bit_i};
  // When the subtraction is taken the true difference is below div_i, so W bits suffice.
  assign diff    = shifted[WIDTH-1:0] - div_i;
  assign q_o     = (shifted >= {1'b0, div_i});
  assign rem_o   = q_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/execute_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module execute_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  // i_start is accepted only while o_busy is low; o_busy rises on the accepting
  // edge and o_done pulses for one cycle on the edge HI/LO take the result.
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_dbg_state
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e             state_q;
  logic               div_q, neg_q, rneg_q, done_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               is_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_bit;
  logic [2*WIDTH-1:0] acc_iter_d, prod;
  logic [WIDTH-1:0]   quot, rem, fix_hi_d, fix_lo_d;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .div_i (b_q),
    .bit_i (acc_q[WIDTH-1]),
    .rem_o (div_rem),
    .q_o   (div_bit)
  );

  always_comb begin
    is_signed = ~i_op[0];
    rs_neg    = is_signed & i_rs[WIDTH-1];
    rt_neg    = is_signed & i_rt[WIDTH-1];
    rs_mag    = rs_neg ? -i_rs : i_rs;
    rt_mag    = rt_neg ? -i_rt : i_rt;
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top;
  // divide keeps the remainder high and shifts quotient bits in as dividend bits leave.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_iter_d = div_q ? {div_rem, acc_q[WIDTH-2:0], div_bit}
                       : {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    fix_hi_d = prod[2*WIDTH-1:WIDTH];
    fix_lo_d = prod[WIDTH-1:0];
    if (div_q) begin
      if (b_q == '0) begin
        fix_lo_d = '1;
        fix_hi_d = rneg_q ? -a_q : a_q;
      end else begin
        fix_lo_d = neg_q ? -quot : quot;
        fix_hi_d = rneg_q ? -rem : rem;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            div_q   <= i_op[1];
            a_q     <= rs_mag;
            b_q     <= rt_mag;
            acc_q   <= i_op[1] ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
            neg_q   <= rs_neg ^ rt_neg;
            rneg_q  <= rs_neg;
            cnt_q   <= CNT_W'(WIDTH);
            state_q <= S_CALC;
          end else begin
            if (i_mthi) hi_q <= i_rs;
            if (i_mtlo) lo_q <= i_rs;
          end
        end
        S_CALC: begin
          acc_q <= acc_iter_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage of the unpipelined MIPS core, beside the main ALU.
- Implements MULT, MULTU, DIV, DIVU into architectural HI/LO registers, plus MTHI/MTLO writes.
- HI/LO feed the MFHI/MFLO path, which drives the ALU-result bus consumed by the memory stage.
- The controller stalls PC and register writeback while o_busy is high.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 4; the core uses 32.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  launch the operation given by i_op; sampled only in IDLE
- i_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_rs  input  WIDTH  multiplicand / dividend; also the MTHI/MTLO data
- i_rt  input  WIDTH  multiplier / divisor
- i_mthi  input  1  write i_rs into HI
- i_mtlo  input  1  write i_rs into LO
- o_busy  output  1  operation in progress
- o_done  output  1  one-cycle pulse when HI/LO are updated by an operation
- o_hi  output  WIDTH  HI register
- o_lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-low; may occur at any time, including mid-operation):
  - FSM goes to IDLE.
  - HI, LO, the iteration counter and all datapath registers clear to 0.
  - o_busy and o_done go to 0.
  - Any in-flight operation is discarded; no o_done is issued for it.
- FSM states: IDLE, CALC, FIX.
  - IDLE to CALC: on i_start. At that edge, latch the op and the absolute values of the operands (absolute value only for signed ops), latch the result signs, and load counter = WIDTH.
  - CALC: one iteration per cycle; counter decrements; on the edge where counter reaches 0, go to FIX.
  - FIX to IDLE: apply sign correction, write HI/LO, and assert o_done for exactly one cycle.
- Latency:
  - Start sampled at edge E0; CALC occupies E1..E32; FIX is written at E33.
  - HI/LO hold the new values and o_done = 1 from E33 to E34.
  - o_busy is high from E0 until E33 (1 from E0 to E33, 0 after E33).
  - A back-to-back i_start is accepted at E34 at the earliest.
- Multiply: shift-add over a 2*WIDTH accumulator, one multiplier bit per iteration. HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - Signed product = two's-complement negation of the 2*WIDTH unsigned product when the operand signs differ.
- Divide: restoring division, one quotient bit per iteration. LO = quotient, HI = remainder.
  - Signed: quotient negative when the operand signs differ; remainder takes the sign of the dividend (truncating division).
  - Operand magnitudes are held as unsigned WIDTH values, so |-2^(WIDTH-1)| is representable.
  - 0x80000000 / -1 (signed) gives LO = 0x80000000, HI = 0.
- Divide by zero (signed or unsigned): LO = all-ones, HI = i_rs as latched. Same latency and o_done pulse; no exception.
- i_start while o_busy: ignored; no state change.
- i_mthi / i_mtlo:
  - In IDLE without i_start: write HI/LO at the next edge; both may be asserted together.
  - In IDLE with i_start in the same cycle: i_start wins and the MT write is dropped.
  - While busy: ignored.
  - MT writes never pulse o_done.
- o_hi / o_lo hold their previous values throughout CALC.
- i_op values are all legal; no illegal-op state.

Decomposition:
- Package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encodings S_IDLE, S_CALC, S_FIX
  - counter width CNT_W = clog2(WIDTH)+1
- Sub-module div_restore_step: combinational single restoring-division iteration.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
  - Instantiated once inside execute_muldiv.
- The FSM, counter and multiply path stay in the top module.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001; o_done exactly 33 edges after the start edge; o_busy high for exactly 33 cycles.
- MULT -3 x 5 (0xFFFFFFFD, 0x00000005): HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- DIVU 100 / 0: LO=0xFFFFFFFF, HI=0x00000064; o_done pulses at normal latency.
- Start a MULTU, pulse i_start with different operands and i_mthi=1 at cycle 5: both ignored; first result unchanged. Then in IDLE, i_mthi=1 with i_rs=0x12345678: HI=0x12345678, no o_done.
- Start a DIV, drop i_rst_n at cycle 10 for a half cycle: o_busy=0 immediately; HI=LO=0; no o_done. A following start completes normally.
